// File: rtl/reg_file_writeback_pkg.sv
// Shared constants and types for the register-file write-side controller.
// Source indices double as grant priority: a lower index wins.
package reg_file_writeback_pkg;

  localparam int REG_ADDR_BITS = 5;
  localparam int XLEN          = 32;
  localparam int NUM_REGS      = 1 << REG_ADDR_BITS;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SRC_LD  = 0;
  localparam int SRC_MD  = 1;
  localparam int SRC_ALU = 2;
  localparam int NUM_SRC = 3;

endpackage

// File: rtl/reg_file_writeback_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reserve, cleared on writeback.
// A reserve and a clear of the same register in one cycle leave the bit set.
module reg_scoreboard
  import reg_file_writeback_pkg::*;
(
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     set_en,
  input  logic [REG_ADDR_BITS-1:0] set_rd,
  input  logic                     clr_en,
  input  logic [REG_ADDR_BITS-1:0] clr_rd,
  input  logic [REG_ADDR_BITS-1:0] query_rs1,
  input  logic [REG_ADDR_BITS-1:0] query_rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic [NUM_REGS-1:0]      pending_map
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  assign set_vec = set_en ? (NUM_REGS'(1) << set_rd) : '0;
  assign clr_vec = clr_en ? (NUM_REGS'(1) << clr_rd) : '0;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pending_map <= '0;
    end else begin
      // x0 is never pending, whatever the requests say.
      pending_map <= ((pending_map & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
    end
  end

  assign rs1_pending = pending_map[query_rs1] && (query_rs1 != '0);
  assign rs2_pending = pending_map[query_rs2] && (query_rs2 != '0);

endmodule

// File: rtl/reg_file_writeback.sv
// Write-port controller for the BRAM register file: zero-fill sweep after reset,
// then fixed-priority arbitration of load, mul/div and ALU results onto one write port.
module reg_file_writeback
  import reg_file_writeback_pkg::*;
(
  input  logic                     clk,
  input  logic                     sync_reset,
  output logic                     init_done,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REG_ADDR_BITS-1:0] ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [REG_ADDR_BITS-1:0] md_rd,
  input  logic [XLEN-1:0]          md_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_ADDR_BITS-1:0] alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     rsv_valid,
  input  logic [REG_ADDR_BITS-1:0] rsv_rd,
  input  logic [REG_ADDR_BITS-1:0] query_rs1,
  input  logic [REG_ADDR_BITS-1:0] query_rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic [NUM_REGS-1:0]      pending_map,
  output logic                     wr_enable,
  output logic [REG_ADDR_BITS-1:0] wr_addr,
  output logic [XLEN-1:0]          wr_data,
  output logic                     fsm_state
);

  localparam logic [REG_ADDR_BITS:0] SWEEP_END = (REG_ADDR_BITS + 1)'(NUM_REGS);

  state_t                   state;
  logic [REG_ADDR_BITS:0]   counter;
  logic                     run;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [NUM_SRC-1:0]       xfer;
  logic [REG_ADDR_BITS-1:0] src_rd   [NUM_SRC];
  logic [XLEN-1:0]          src_data [NUM_SRC];
  logic                     xfer_any;
  logic [REG_ADDR_BITS-1:0] sel_rd;
  logic [XLEN-1:0]          sel_data;
  logic                     blocked;

  assign run = (state == RUN) && !sync_reset;

  assign src_valid[SRC_LD]  = ld_valid;
  assign src_valid[SRC_MD]  = md_valid;
  assign src_valid[SRC_ALU] = alu_valid;
  assign src_rd[SRC_LD]     = ld_rd;
  assign src_rd[SRC_MD]     = md_rd;
  assign src_rd[SRC_ALU]    = alu_rd;
  assign src_data[SRC_LD]   = ld_data;
  assign src_data[SRC_MD]   = md_data;
  assign src_data[SRC_ALU]  = alu_data;

  // valid/ready: a result moves when both are high in the same cycle; a source is
  // ready only while every higher-priority source is idle, so at most one moves.
  always_comb begin
    blocked  = 1'b0;
    src_ready = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = run && !blocked;
      blocked      = blocked || src_valid[i];
    end
    xfer = src_valid & src_ready;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) begin
        sel_rd   = src_rd[i];
        sel_data = src_data[i];
      end
    end
  end

  assign xfer_any  = |xfer;
  assign ld_ready  = src_ready[SRC_LD];
  assign md_ready  = src_ready[SRC_MD];
  assign alu_ready = src_ready[SRC_ALU];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state     <= INIT;
      counter   <= '0;
      init_done <= 1'b0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (counter == SWEEP_END) begin
            state     <= RUN;
            init_done <= 1'b1;
            wr_enable <= 1'b0;
          end else begin
            wr_enable <= 1'b1;
            wr_addr   <= counter[REG_ADDR_BITS-1:0];
            wr_data   <= '0;
            counter   <= counter + 1'b1;
          end
        end
        RUN: begin
          if (xfer_any) begin
            wr_enable <= (sel_rd != '0);
            wr_addr   <= sel_rd;
            wr_data   <= sel_data;
          end else begin
            wr_enable <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .set_en      (run && rsv_valid && (rsv_rd != '0)),
    .set_rd      (rsv_rd),
    .clr_en      (xfer_any),
    .clr_rd      (sel_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .pending_map (pending_map)
  );

endmodule

// File: tb/tb_reg_file_writeback.sv
// Bench for reg_file_writeback: directed sweep/arbitration/scoreboard steps, then
// randomized producer traffic checked against a queue-and-array reference model.
module tb_reg_file_writeback;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int W  = 1 + AW + DW;

  logic          clk;
  logic          sync_reset;
  logic          init_done;
  logic          ld_valid, md_valid, alu_valid;
  logic          ld_ready, md_ready, alu_ready;
  logic [AW-1:0] ld_rd, md_rd, alu_rd;
  logic [DW-1:0] ld_data, md_data, alu_data;
  logic          rsv_valid;
  logic [AW-1:0] rsv_rd;
  logic [AW-1:0] query_rs1, query_rs2;
  logic          rs1_pending, rs2_pending;
  logic [NR-1:0] pending_map;
  logic          wr_enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fsm_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  bit           pend [NR];
  bit           pv   [3];
  logic [AW-1:0] prd [3];
  logic [DW-1:0] pdat[3];

  reg_file_writeback dut (
    .clk(clk), .sync_reset(sync_reset), .init_done(init_done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .pending_map(pending_map),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    ld_valid = 0; md_valid = 0; alu_valid = 0; rsv_valid = 0;
    ld_rd = 0; md_rd = 0; alu_rd = 0; rsv_rd = 0;
    ld_data = 0; md_data = 0; alu_data = 0;
    query_rs1 = 0; query_rs2 = 0;
  endtask

  task automatic drive_producers();
    ld_valid  = pv[0]; ld_rd  = prd[0]; ld_data  = pdat[0];
    md_valid  = pv[1]; md_rd  = prd[1]; md_data  = pdat[1];
    alu_valid = pv[2]; alu_rd = prd[2]; alu_data = pdat[2];
  endtask

  function automatic logic [NR-1:0] pack_pend();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_enable"}, 64'(wr_enable), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_pending_map"}, 64'(pending_map), 64'd0);
    chk({tag, "_readies"}, 64'({ld_ready, md_ready, alu_ready}), 64'd0);
    chk({tag, "_rs_pending"}, 64'({rs1_pending, rs2_pending}), 64'd0);
  endtask

  // Full zero-fill sweep, producers busy the whole time to show they are held off.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < NR; i++) begin
      step();
      chk({tag, "_sweep_en"}, 64'(wr_enable), 64'd1);
      chk({tag, "_sweep_addr"}, 64'(wr_addr), 64'(i));
      chk({tag, "_sweep_data"}, 64'(wr_data), 64'd0);
      chk({tag, "_sweep_done"}, 64'(init_done), 64'd0);
      chk({tag, "_sweep_ready"}, 64'({ld_ready, md_ready, alu_ready}), 64'd0);
      chk({tag, "_sweep_pmap"}, 64'(pending_map), 64'd0);
      if (i == NR - 1) begin
        drive_idle();
      end else begin
        ld_valid = 1; md_valid = 1; alu_valid = 1;
        ld_rd = AW'($urandom_range(1, NR - 1));
        rsv_valid = 1; rsv_rd = AW'($urandom_range(1, NR - 1));
      end
    end
    step();
    chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    chk({tag, "_post_sweep_en"}, 64'(wr_enable), 64'd0);
    chk({tag, "_post_sweep_pmap"}, 64'(pending_map), 64'd0);
  endtask

  initial begin
    int g;
    logic [W-1:0] e;
    logic [DW-1:0] d;

    drive_idle();
    sync_reset = 1;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    for (int s = 0; s < 3; s++) begin pv[s] = 0; prd[s] = 0; pdat[s] = 0; end

    // reset state, including combinational readies held low while producers are valid
    step(); step();
    ld_valid = 1; md_valid = 1; alu_valid = 1;
    settle();
    chk_reset_outputs("reset");
    drive_idle();
    sync_reset = 0;
    check_sweep("init");

    // priority: all three valid at once, each holds until granted
    ld_valid = 1; ld_rd = 5; ld_data = 32'hAAAA5555;
    md_valid = 1; md_rd = 6; md_data = 32'h12345678;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hDEADBEEF;
    settle();
    chk("prio_ready_1", 64'({ld_ready, md_ready, alu_ready}), 64'b100);
    step();
    chk("prio_wr5", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 5'd5, 32'hAAAA5555}));
    ld_valid = 0;
    settle();
    chk("prio_ready_2", 64'({md_ready, alu_ready}), 64'b10);
    step();
    chk("prio_wr6", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 5'd6, 32'h12345678}));
    md_valid = 0;
    settle();
    chk("prio_ready_3", 64'(alu_ready), 64'd1);
    step();
    chk("prio_wr7", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 5'd7, 32'hDEADBEEF}));
    alu_valid = 0;
    step();
    chk("idle_hold", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b0, 5'd7, 32'hDEADBEEF}));

    // x0 write is accepted but never reaches the register file
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    settle();
    chk("x0_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 0;
    chk("x0_no_write", 64'(wr_enable), 64'd0);
    chk("x0_pmap", 64'(pending_map), 64'd0);

    // reserve then write back x9
    rsv_valid = 1; rsv_rd = 9;
    step();
    rsv_valid = 0; query_rs1 = 9; query_rs2 = 0;
    settle();
    chk("rsv9_pmap", 64'(pending_map), 64'(32'h1 << 9));
    chk("rsv9_rs1", 64'(rs1_pending), 64'd1);
    chk("rs2_x0", 64'(rs2_pending), 64'd0);
    alu_valid = 1; alu_rd = 9; alu_data = 32'hCAFE0009;
    step();
    alu_valid = 0;
    chk("wb9_wr", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 5'd9, 32'hCAFE0009}));
    chk("wb9_pmap", 64'(pending_map), 64'd0);
    chk("wb9_rs1", 64'(rs1_pending), 64'd0);

    // same-cycle reserve and clear of x3: reserve wins
    rsv_valid = 1; rsv_rd = 3;
    step();
    md_valid = 1; md_rd = 3; md_data = 32'h33333333;
    step();
    rsv_valid = 0; md_valid = 0;
    chk("rc3_wr", 64'({wr_enable, wr_addr, wr_data}), 64'({1'b1, 5'd3, 32'h33333333}));
    chk("rc3_pmap", 64'(pending_map), 64'(32'h1 << 3));
    query_rs2 = 3;
    settle();
    chk("rc3_rs2", 64'(rs2_pending), 64'd1);
    // re-reserve of a pending register keeps a single bit; one write clears it
    rsv_valid = 1; rsv_rd = 3;
    step();
    rsv_valid = 0;
    md_valid = 1; md_rd = 3; md_data = 32'h44444444;
    step();
    md_valid = 0;
    chk("clr3_pmap", 64'(pending_map), 64'd0);
    drive_idle();
    step();

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!pv[s] && ($urandom_range(0, 1) == 1)) begin
          pv[s] = 1;
          prd[s] = AW'($urandom_range(0, NR - 1));
          pdat[s] = $urandom;
        end
      end
      drive_producers();
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_rd = AW'($urandom_range(0, NR - 1));
      query_rs1 = AW'($urandom_range(0, NR - 1));
      query_rs2 = AW'($urandom_range(0, NR - 1));
      settle();
      chk("rnd_rs1", 64'(rs1_pending), 64'(pend[query_rs1]));
      chk("rnd_rs2", 64'(rs2_pending), 64'(pend[query_rs2]));
      chk("rnd_ld_ready", 64'(ld_ready), 64'd1);
      chk("rnd_md_ready", 64'(md_ready), 64'(!pv[0]));
      chk("rnd_alu_ready", 64'(alu_ready), 64'(!pv[0] && !pv[1]));
      g = -1;
      for (int s = 0; s < 3; s++) if (pv[s] && g < 0) g = s;
      if (g >= 0) begin
        exp_q.push_back({prd[g] != 0, prd[g], pdat[g]});
        if (prd[g] != 0) pend[prd[g]] = 0;
        pv[g] = 0;
      end else begin
        exp_q.push_back('0);
      end
      if (rsv_valid && rsv_rd != 0) pend[rsv_rd] = 1;
      step();
      e = exp_q.pop_front();
      chk("rnd_wr_enable", 64'(wr_enable), 64'(e[W-1]));
      if (e[W-1]) begin
        chk("rnd_wr_addr", 64'(wr_addr), 64'(e[W-2 -: AW]));
        chk("rnd_wr_data", 64'(wr_data), 64'(e[DW-1:0]));
      end
      chk("rnd_pmap", 64'(pending_map), 64'(pack_pend()));
    end
    drive_idle();
    for (int s = 0; s < 3; s++) pv[s] = 0;
    step();

    // reset mid-RUN drops an in-flight write and clears the scoreboard
    rsv_valid = 1; rsv_rd = 12;
    step();
    pend[12] = 1;
    chk("midrun_pmap", 64'(pending_map), 64'(pack_pend()));
    rsv_valid = 0;
    d = $urandom;
    alu_valid = 1; alu_rd = 12; alu_data = d;
    sync_reset = 1;
    settle();
    chk("midrun_alu_ready", 64'(alu_ready), 64'd0);
    step();
    drive_idle();
    chk_reset_outputs("midrun");
    sync_reset = 0;

    // reset pulsed during the sweep write of x10 restarts the sweep from x0
    for (int i = 0; i <= 10; i++) begin
      step();
      chk("partial_sweep_addr", 64'(wr_addr), 64'(i));
    end
    sync_reset = 1;
    step();
    chk_reset_outputs("midinit");
    sync_reset = 0;
    check_sweep("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
